// File: rtl/nn_bgt_sched.sv
// Round-robin burst-gate scheduler: grants one fixed-length burst plus refractory gap per request event.
// Optional NN_BGT_SCHED_DROP_EN: discard request events that arrive while a burst/refractory is in progress.
module nn_bgt_sched #(
    parameter int N                   = 4,
    parameter int ID_W                = 2,
    parameter int PULSE_DURATION      = 10,
    parameter int REFRACTORY_DURATION = 10,
    parameter int COUNTER_SIZE        = 8
) (
    input  logic            CLK,
    input  logic            INIT_N,
    input  logic            EN,
    input  logic [N-1:0]    REQ,
    output logic            OUT,
    output logic [N-1:0]    GNT,
    output logic [ID_W-1:0] WINNER,
    output logic            BUSY,
    output logic [N-1:0]    PEND
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BURST   = 2'd1;
    localparam logic [1:0] REFRACT = 2'd2;

    localparam logic [COUNTER_SIZE-1:0] PULSE_LAST = COUNTER_SIZE'(PULSE_DURATION - 1);
    localparam logic [COUNTER_SIZE-1:0] REFR_LAST  =
        COUNTER_SIZE'((REFRACTORY_DURATION > 0) ? REFRACTORY_DURATION - 1 : 0);
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(N - 1);
    localparam logic [N-1:0]    ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]              state;
    logic [COUNTER_SIZE-1:0] cnt;
    logic [N-1:0]            req_d;
    logic [N-1:0]            pend;
    logic [N-1:0]            gnt;
    logic [ID_W-1:0]         last;
    logic [ID_W-1:0]         winner;
    logic                    out_r;
    logic                    busy;

    logic [N-1:0]            ev;
    logic [N-1:0]            rot;
    logic [N-1:0]            sel_oh;
    logic [N-1:0]            clr;
    logic [ID_W-1:0]         sel_idx;
    logic                    found;
    logic                    grant;
    int unsigned             start;
    int unsigned             off;

    always_comb begin
        ev = REQ & ~req_d;
`ifdef NN_BGT_SCHED_DROP_EN
        if (state != IDLE) ev = '0;
`endif
    end

    // Rotate PEND so the search start lands on bit 0, then count up to the first set bit.
    always_comb begin
        start = (32'(last) + 32'd1) % 32'(N);
        rot   = N'({pend, pend} >> start);
        found = 1'b0;
        off   = 0;
        for (int unsigned k = 0; k < 32'(N); k++) begin
            if (!found) begin
                if (rot[0]) begin
                    found = 1'b1;
                end else begin
                    rot = rot >> 1;
                    off = off + 1;
                end
            end
        end
        sel_idx = ID_W'((start + off) % 32'(N));
        sel_oh  = found ? (ONE_HOT0 << sel_idx) : '0;
        grant   = (state == IDLE) && EN && found;
        clr     = grant ? sel_oh : '0;
    end

    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            state  <= IDLE;
            cnt    <= '0;
            req_d  <= '0;
            pend   <= '0;
            gnt    <= '0;
            last   <= LAST_INIT;
            winner <= '0;
            out_r  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            req_d <= REQ;
            pend  <= (pend | ev) & ~clr;
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt    <= sel_oh;
                        last   <= sel_idx;
                        winner <= sel_idx;
                        out_r  <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= BURST;
                    end
                end
                BURST: begin
                    if (cnt == PULSE_LAST) begin
                        out_r <= 1'b0;
                        gnt   <= '0;
                        cnt   <= '0;
                        if (REFRACTORY_DURATION == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= REFRACT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REFRACT: begin
                    if (cnt == REFR_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    out_r <= 1'b0;
                    gnt   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign OUT    = out_r;
    assign GNT    = gnt;
    assign WINNER = winner;
    assign BUSY   = busy;
    assign PEND   = pend;

endmodule

// File: tb/tb_nn_bgt_sched.sv
// Self-checking bench for nn_bgt_sched: directed scenarios with literal expectations plus a randomized
// run, all compared every cycle against a countdown-based behavioural model.
module tb_nn_bgt_sched;

    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int P    = 3;
    localparam int R    = 2;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic            clk;
    logic            init_n;
    logic            en;
    logic [N-1:0]    req;
    logic            out;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] winner;
    logic            busy;
    logic [N-1:0]    pend;

    int errors = 0;
    int checks = 0;

    nn_bgt_sched #(
        .N(N), .ID_W(ID_W), .PULSE_DURATION(P), .REFRACTORY_DURATION(R), .COUNTER_SIZE(8)
    ) dut (
        .CLK(clk), .INIT_N(init_n), .EN(en), .REQ(req),
        .OUT(out), .GNT(gnt), .WINNER(winner), .BUSY(busy), .PEND(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a grant loads "cycles left" counters for the pulse and for the whole busy period.
    logic [N-1:0] m_pend, m_reqd, m_gnt, m_ev, m_oh;
    int m_last, m_winner, out_left, busy_left, m_pick;

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int pick_winner(input logic [N-1:0] p, input int lst);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (lst + k) % N;
            if (bit_at(p, idx)) return idx;
        end
        return -1;
    endfunction

    always_comb begin
        m_ev = req & ~m_reqd;
`ifdef NN_BGT_SCHED_DROP_EN
        if (busy_left != 0) m_ev = '0;
`endif
        m_pick = (busy_left == 0 && en) ? pick_winner(m_pend, m_last) : -1;
        m_oh   = (m_pick >= 0) ? (ONE << m_pick) : '0;
    end

    always @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            m_pend    <= '0;
            m_reqd    <= '0;
            m_gnt     <= '0;
            m_last    <= N - 1;
            m_winner  <= 0;
            out_left  <= 0;
            busy_left <= 0;
        end else begin
            m_reqd <= req;
            m_pend <= (m_pend | m_ev) & ~m_oh;
            if (m_pick >= 0) begin
                m_gnt     <= m_oh;
                m_last    <= m_pick;
                m_winner  <= m_pick;
                out_left  <= P;
                busy_left <= P + R;
            end else begin
                if (out_left == 1) m_gnt <= '0;
                if (out_left > 0) out_left <= out_left - 1;
                if (busy_left > 0) busy_left <= busy_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("OUT",    32'(out),    (out_left > 0) ? 1 : 0);
        chk("BUSY",   32'(busy),   (busy_left > 0) ? 1 : 0);
        chk("GNT",    32'(gnt),    32'(m_gnt));
        chk("PEND",   32'(pend),   32'(m_pend));
        chk("WINNER", 32'(winner), m_winner);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        init_n = 1'b0;
        cyc(1);
        init_n = 1'b1;
    endtask

    initial begin : stim
        int oc, bc, d, seen;
        logic [N-1:0] flip;

        // Reset with all requests high.
        init_n = 1'b0;
        en     = 1'b0;
        req    = 4'b1111;
        #3;
        chk("rst_out",    32'(out),    0);
        chk("rst_gnt",    32'(gnt),    0);
        chk("rst_busy",   32'(busy),   0);
        chk("rst_pend",   32'(pend),   0);
        chk("rst_winner", 32'(winner), 0);
        @(negedge clk);
        init_n = 1'b1;
        cyc(1);
        chk("rel_pend", 32'(pend), 'b1111);
        cyc(3);
        chk("en0_out",  32'(out),  0);
        chk("en0_busy", 32'(busy), 0);
        en = 1'b1;
        cyc(1);
        chk("en1_gnt",    32'(gnt),    'b0001);
        chk("en1_winner", 32'(winner), 0);
        chk("en1_out",    32'(out),    1);
        req = '0;
        cyc(30);
        chk("drain_pend", 32'(pend), 0);

        // Single request on channel 2.
        do_reset();
        req = 4'b0100;
        cyc(1);
        chk("single_pend", 32'(pend), 'b0100);
        chk("single_gnt0", 32'(gnt),  0);
        cyc(1);
        chk("single_gnt",    32'(gnt),    'b0100);
        chk("single_winner", 32'(winner), 2);
        oc = 0;
        bc = 0;
        for (int i = 0; i < 9; i++) begin
            if (out)  oc++;
            if (busy) bc++;
            cyc(1);
        end
        chk("single_out_len",  oc, P);
        chk("single_busy_len", bc, P + R);
        req = '0;

        // Contention 1 vs 3, then 0 vs 3 after LAST=3.
        do_reset();
        req = 4'b1010;
        cyc(2);
        chk("cont_first", 32'(gnt), 'b0010);
        d    = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (seen == 0) d++;
            if (seen == 0 && gnt == 4'b1000) seen = 1;
        end
        chk("cont_second_seen", seen, 1);
        chk("cont_spacing",     d,    P + R + 1);
        req = '0;
        cyc(1);
        req = 4'b1001;
        cyc(1);
        chk("rr_pend", 32'(pend), 'b1001);
        cyc(1);
        chk("rr_gnt", 32'(gnt), 'b0001);
        req = '0;
        cyc(15);

        // Request arriving during another channel's burst.
        do_reset();
        req = 4'b0010;
        cyc(2);
        chk("dur_gnt1", 32'(gnt), 'b0010);
        req = 4'b0011;
        cyc(1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (gnt == 4'b0001) seen = 1;
            cyc(1);
        end
`ifdef NN_BGT_SCHED_DROP_EN
        chk("dur_dropped", seen, 0);
`else
        chk("dur_served", seen, 1);
`endif
        req = '0;

        // Enable gating with a single pending request.
        en = 1'b0;
        do_reset();
        req = 4'b0001;
        cyc(4);
        chk("gate_pend", 32'(pend), 'b0001);
        chk("gate_out",  32'(out),  0);
        chk("gate_busy", 32'(busy), 0);
        en = 1'b1;
        cyc(1);
        chk("gate_gnt", 32'(gnt), 'b0001);
        req = '0;
        cyc(10);

        // Asynchronous reset in the second burst cycle.
        do_reset();
        req = 4'b0100;
        cyc(2);
        chk("mid_gnt", 32'(gnt), 'b0100);
        req = 4'b0110;
        cyc(1);
        #2;
        init_n = 1'b0;
        #1;
        chk("mid_out",  32'(out),  0);
        chk("mid_gnt0", 32'(gnt),  0);
        chk("mid_pend", 32'(pend), 0);
        chk("mid_busy", 32'(busy), 0);
        req = '0;
        cyc(1);
        init_n = 1'b1;
        oc = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (out) oc++;
        end
        chk("mid_no_burst", oc, 0);

        // Randomized traffic, with one asynchronous reset partway.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            flip = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            req  = req ^ flip;
            en   = ($urandom_range(0, 7) != 0);
            if (i == 400) begin
                #2;
                init_n = 1'b0;
                @(negedge clk);
                init_n = 1'b1;
            end
        end
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
